// File: rtl/async_fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package   : params
// Purpose   : Shared widths and the read-side burst FSM state type.
// Revision  : 1.0  initial release
// ============================================================================
package params;

    localparam int FIFO_WIDTH        = 8;
    localparam int LEN_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/async_fifo_reader_skid_buf2.sv
`default_nettype none
// ============================================================================
// Module    : skid_buf2
// Purpose   : Two-entry valid/ready buffer; head entry drives the output.
// Revision  : 1.0  initial release
// ============================================================================
module skid_buf2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [1:0]       o_occ,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (r_occ != 2'd0);
    // A full buffer can still take a word when the head leaves in the same cycle.
    assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (w_push) r_head <= i_push_data;
                end
                2'd1: begin
                    if (w_push && w_pop) r_head <= i_push_data;
                    else if (w_push)     r_tail <= i_push_data;
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_push) r_tail <= i_push_data;
                    end
                end
            endcase

            if (w_push && !w_pop)      r_occ <= r_occ + 2'd1;
            else if (w_pop && !w_push) r_occ <= r_occ - 2'd1;
        end
    end

    assign o_occ   = r_occ;
    assign o_valid = (r_occ != 2'd0);
    assign o_head  = r_head;

endmodule
`default_nettype wire

// File: rtl/async_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module    : async_fifo_reader
// Purpose   : Drains a fixed-length burst from the async FIFO read port onto
//             a valid/ready stream, tagging the last word and pulsing done.
// Revision  : 1.0  initial release
// ============================================================================
module async_fifo_reader
    import params::*;
#(
    parameter int DATA_WIDTH = FIFO_WIDTH,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEFAULT
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam logic [LEN_WIDTH-1:0] c_ONE = LEN_WIDTH'(1);

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_issue_cnt;
    logic [LEN_WIDTH-1:0]  r_out_cnt;
    logic                  w_rinc;
    logic                  w_pop;
    logic                  w_valid;
    logic [1:0]            w_occ;
    logic [DATA_WIDTH:0]   w_head;
    logic [DATA_WIDTH:0]   w_push_data;

    assign w_pop       = w_valid && m_ready;
    assign w_push_data = {(r_issue_cnt == c_ONE), rdata};

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // rinc looks only at registered state and rempty, never at m_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_rinc      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = (len == '0) ? DONE : RUN;
            end
            RUN: begin
                w_rinc = !rempty && (r_issue_cnt != '0) && (w_occ < 2'd2);
                if (w_pop && (r_out_cnt == c_ONE)) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_issue_cnt <= len;
            r_out_cnt   <= len;
        end else begin
            if (w_rinc)                     r_issue_cnt <= r_issue_cnt - c_ONE;
            if (w_pop && (r_out_cnt != '0)) r_out_cnt   <= r_out_cnt - c_ONE;
        end
    end

    skid_buf2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk         (rclk),
        .rst         (rrst),
        .i_push      (w_rinc),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_valid     (w_valid),
        .o_head      (w_head)
    );

    assign rinc    = w_rinc;
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign m_valid = w_valid;
    assign m_data  = w_head[DATA_WIDTH-1:0];
    assign m_last  = w_head[DATA_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module    : tb_async_fifo_reader
// Purpose   : Self-checking bench for async_fifo_reader against a queue model.
// Revision  : 1.0  initial release
// ============================================================================
module tb_async_fifo_reader;

    logic       rclk;
    logic       rrst_n;
    logic       start;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic       rempty;
    logic       rinc;
    logic [7:0] rdata;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    async_fifo_reader #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (8)
    ) dut (
        .rclk    (rclk),
        .rrst    (~rrst_n),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .rempty  (rempty),
        .rinc    (rinc),
        .rdata   (rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Reference model: FIFO contents, words in flight to the consumer, burst bookkeeping.
    logic [7:0] fifo_q[$];
    logic [8:0] exp_q[$];
    int  rem_reads, rem_hs;
    bit  in_burst, done_due;
    int  n_vec, n_err;
    int  n_rinc, n_done, n_hs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        in_burst  = 1'b0;
        done_due  = 1'b0;
        rem_reads = 0;
        rem_hs    = 0;
    endtask

    // One clock: present FIFO head, check outputs, advance model at the edge.
    task automatic cycle();
        logic       e_valid;
        logic       e_rinc;
        logic       hs;
        logic [7:0] w;
        e_valid = 1'b0;
        e_rinc  = 1'b0;
        rempty  = (fifo_q.size() == 0);
        rdata   = rempty ? 8'h00 : fifo_q[0];
        #1;
        if (!rrst_n) begin
            chk("rst_busy",   busy,    0);
            chk("rst_done",   done,    0);
            chk("rst_rinc",   rinc,    0);
            chk("rst_valid",  m_valid, 0);
            chk("rst_last",   m_last,  0);
            chk("rst_data",   m_data,  0);
        end else begin
            e_valid = (exp_q.size() != 0);
            e_rinc  = in_burst && !done_due && !rempty && (rem_reads != 0) && (exp_q.size() < 2);
            chk("busy",    busy,    in_burst);
            chk("done",    done,    done_due);
            chk("rinc",    rinc,    e_rinc);
            chk("m_valid", m_valid, e_valid);
            if (e_valid) begin
                chk("m_data", m_data, exp_q[0][7:0]);
                chk("m_last", m_last, exp_q[0][8]);
            end
            if (done === 1'b1) n_done++;
        end
        hs = e_valid && m_ready;
        @(posedge rclk);
        if (rrst_n) begin
            if (done_due) begin
                in_burst = 1'b0;
                done_due = 1'b0;
            end else if (in_burst) begin
                if (hs) begin
                    void'(exp_q.pop_front());
                    rem_hs--;
                    n_hs++;
                    if (rem_hs == 0) done_due = 1'b1;
                end
                if (e_rinc) begin
                    w = fifo_q.pop_front();
                    exp_q.push_back({(rem_reads == 1), w});
                    rem_reads--;
                    n_rinc++;
                end
            end else if (start) begin
                in_burst  = 1'b1;
                rem_reads = int'(len);
                rem_hs    = int'(len);
                if (len == 8'd0) done_due = 1'b1;
            end
        end
        @(negedge rclk);
    endtask

    task automatic run_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && in_burst; i++) cycle();
        chk("burst_ends", in_burst, 0);
        cycle();
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
    endtask

    initial begin
        int r0, d0, h0, blen, pend, k;
        n_vec = 0; n_err = 0; n_rinc = 0; n_done = 0; n_hs = 0;
        model_reset();
        rrst_n = 1'b0; start = 1'b0; len = 8'd0; m_ready = 1'b0;
        rempty = 1'b1; rdata = 8'h00;
        @(negedge rclk);
        repeat (2) cycle();
        rrst_n = 1'b1;
        cycle();

        // Basic burst of four
        fill(8'h10, 4);
        m_ready = 1'b1; r0 = n_rinc; d0 = n_done;
        start = 1'b1; len = 8'd4; cycle(); start = 1'b0;
        run_idle(50);
        chk("basic_reads", n_rinc - r0, 4);
        chk("basic_done",  n_done - d0, 1);

        // Zero length: no reads, FIFO untouched
        fifo_q.push_back(8'h55);
        r0 = n_rinc; d0 = n_done;
        start = 1'b1; len = 8'd0; cycle(); start = 1'b0;
        run_idle(10);
        chk("zero_reads", n_rinc - r0, 0);
        chk("zero_done",  n_done - d0, 1);
        chk("zero_fifo",  fifo_q.size(), 1);
        fifo_q.delete();

        // Backpressure: two reads then hold
        fill(8'h20, 8);
        m_ready = 1'b0; r0 = n_rinc;
        start = 1'b1; len = 8'd8; cycle(); start = 1'b0;
        repeat (10) cycle();
        chk("bp_reads_held", n_rinc - r0, 2);
        m_ready = 1'b1;
        run_idle(50);
        chk("bp_reads_total", n_rinc - r0, 8);

        // Empty stall, then writer tops up
        fifo_q.delete();
        fill(8'h30, 2);
        r0 = n_rinc; d0 = n_done;
        start = 1'b1; len = 8'd5; cycle(); start = 1'b0;
        repeat (8) cycle();
        chk("stall_reads", n_rinc - r0, 2);
        chk("stall_busy",  busy, 1);
        fill(8'hA0, 3);
        run_idle(50);
        chk("stall_reads_total", n_rinc - r0, 5);
        chk("stall_done", n_done - d0, 1);

        // Start while busy is ignored
        fill(8'h40, 12);
        r0 = n_rinc; d0 = n_done;
        start = 1'b1; len = 8'd3; cycle();
        len = 8'd9; repeat (2) cycle();
        start = 1'b0; len = 8'd0;
        run_idle(50);
        chk("sbusy_reads", n_rinc - r0, 3);
        chk("sbusy_done",  n_done - d0, 1);
        fifo_q.delete();

        // Reset after three handshakes, then resume with a short burst
        fill(8'h60, 8);
        d0 = n_done; h0 = n_hs;
        start = 1'b1; len = 8'd6; cycle(); start = 1'b0;
        for (int i = 0; i < 40 && (n_hs - h0) < 3; i++) cycle();
        chk("rst_hs_reached", n_hs - h0, 3);
        rrst_n = 1'b0;
        #1;
        chk("rst_now_busy",  busy,    0);
        chk("rst_now_rinc",  rinc,    0);
        chk("rst_now_valid", m_valid, 0);
        chk("rst_now_data",  m_data,  0);
        chk("rst_now_last",  m_last,  0);
        model_reset();
        repeat (2) cycle();
        chk("rst_no_done", n_done - d0, 0);
        rrst_n = 1'b1;
        r0 = n_rinc;
        start = 1'b1; len = 8'd2; cycle(); start = 1'b0;
        run_idle(50);
        chk("rst_resume_reads", n_rinc - r0, 2);

        // Randomized bursts with random backpressure and late writes
        for (int b = 0; b < 6; b++) begin
            blen = int'($urandom_range(12, 1));
            k    = int'($urandom_range(blen, 0));
            for (int i = 0; i < k; i++) fifo_q.push_back(8'($urandom));
            pend = blen - k;
            d0 = n_done;
            m_ready = 1'($urandom_range(1, 0));
            start = 1'b1; len = 8'(blen); cycle(); start = 1'b0;
            for (int i = 0; i < 400 && in_burst; i++) begin
                m_ready = ($urandom_range(3, 0) != 0);
                if (pend > 0 && $urandom_range(1, 0) == 1) begin
                    fifo_q.push_back(8'($urandom));
                    pend--;
                end
                cycle();
            end
            chk("rand_burst_ends", in_burst, 0);
            chk("rand_done", n_done - d0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
